// File: rtl/irq_pending_arbiter_pkg.sv
// Shared constants and types for the pending-interrupt arbiter.
package irq_arb_pkg;
    localparam int NUM_SRC = 8;
    localparam int ID_W    = 3;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OFFER = 1'b1
    } arb_state_t;
endpackage

// File: rtl/irq_pending_arbiter_if.sv
// Valid/ready offer channel carrying the granted source ID downstream.
interface irq_pending_arbiter_if;
    import irq_arb_pkg::*;

    logic            irq_valid;
    logic            irq_ready;
    logic [ID_W-1:0] irq_id;

    modport master (output irq_valid, output irq_id, input  irq_ready);
    modport slave  (input  irq_valid, input  irq_id, output irq_ready);
endinterface

// File: rtl/irq_pending_arbiter_prio_enc8.sv
// 8-to-3 priority encoder; bit 7 has the highest priority.
module prio_enc8
    import irq_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] vec,
    input  logic               en,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        idx = '0;
        any = 1'b0;
        if (en) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (vec[i]) begin
                    idx = ID_W'(i);
                    any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/irq_pending_arbiter.sv
// Sticky pending register with edge/level capture, masking and a
// hold-until-accepted offer of the highest-index enabled source.
module irq_pending_arbiter
    import irq_arb_pkg::*;
#(
    parameter int EDGE_MODE = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [NUM_SRC-1:0]          req,
    input  logic [NUM_SRC-1:0]          mask,
    irq_pending_arbiter_if.master       irq,
    output logic [NUM_SRC-1:0]          pending,
    output logic                        overflow
);

    logic [NUM_SRC-1:0] req_s, req_d;
    logic [NUM_SRC-1:0] set, clr, cand;
    logic [ID_W-1:0]    enc_idx;
    logic               enc_any;
    arb_state_t         state;

    // Two-stage sample of the request lines; req_d provides the edge reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_s <= '0;
            req_d <= '0;
        end else begin
            req_s <= req;
            req_d <= req_s;
        end
    end

    // Set events and clear-on-grant of the currently offered source.
    always_comb begin
        set = (EDGE_MODE != 0) ? (req_s & ~req_d) : req_s;
        clr = '0;
        if (irq.irq_valid && irq.irq_ready)
            clr[irq.irq_id] = 1'b1;
    end

    assign cand = pending & mask;

    prio_enc8 u_enc (
        .vec (cand),
        .en  (en),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Pending update: a set arriving with a clear on the same bit wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= (pending & ~clr) | set;
            overflow <= |(set & pending & ~clr);
        end
    end

    // Offer FSM: latch an ID when idle, hold it until the consumer accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ARB_IDLE;
            irq.irq_valid <= 1'b0;
            irq.irq_id    <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (en && enc_any) begin
                        irq.irq_id    <= enc_idx;
                        irq.irq_valid <= 1'b1;
                        state         <= ARB_OFFER;
                    end
                end
                ARB_OFFER: begin
                    if (irq.irq_ready) begin
                        irq.irq_valid <= 1'b0;
                        state         <= ARB_IDLE;
                    end
                end
                default: begin
                    irq.irq_valid <= 1'b0;
                    state         <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
